// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_pkg
// Purpose  : Shared definitions for the immediate-extension pipeline:
//            extension mode encoding and datapath-wide default widths.
// Contents : imm_mode_t, MODE_* constants, IMM_IN_W, IMM_OUT_W
// Revision : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

    // Datapath-wide defaults for the raw immediate and the extended operand
    localparam int IMM_IN_W  = 16;
    localparam int IMM_OUT_W = 32;

    // Extension mode select
    typedef enum logic [1:0] {
        MODE_SEXT   = 2'b00,
        MODE_ZEXT   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } imm_mode_t;

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_core
// Purpose  : Purely combinational immediate extender.
// Ports    : imm_i  [IN_W]  raw immediate
//            mode_i [2]     extension mode (SEXT/ZEXT/UPPER/BRANCH)
//            ext_o  [OUT_W] extended operand
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W
) (
    input  logic [IN_W-1:0]  imm_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] ext_o
);

    logic [OUT_W-1:0] w_sext;

    assign w_sext = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

    always_comb begin
        ext_o = w_sext;
        case (imm_mode_t'(mode_i))
            MODE_SEXT:   ext_o = w_sext;
            MODE_ZEXT:   ext_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
            MODE_UPPER:  ext_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
            // Word offset to byte offset; the two top sign bits fall off
            MODE_BRANCH: ext_o = {w_sext[OUT_W-3:0], 2'b00};
            default:     ext_o = w_sext;
        endcase
    end

endmodule : imm_ext_core
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_pipe
// Purpose  : Pipelined immediate generator. Extends the incoming immediate
//            at the write port and buffers result + tag in a DEPTH-entry
//            FIFO with valid/ready handshakes on both sides.
// Ports    : clk, reset (async, active-high), flush (sync discard)
//            in_valid/in_ready/in_imm/in_mode/in_tag   - producer side
//            out_valid/out_ready/out_data/out_tag      - consumer side
//            count                                     - occupied entries
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_imm,
    input  logic [1:0]                 in_mode,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W   = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  C_LAST  = PTR_W'(DEPTH-1);

    logic [OUT_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;

    // Explicit wrap so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm_i  (in_imm),
        .mode_i (in_mode),
        .ext_o  (w_ext)
    );

    // Ready depends on occupancy only: no pass-through when full
    assign in_ready  = (count_q < C_DEPTH);
    assign out_valid = (count_q != '0);
    assign out_data  = data_q[rd_ptr_q];
    assign out_tag   = tag_q[rd_ptr_q];
    assign count     = count_q;

    assign w_push = in_valid  & in_ready  & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (w_push) begin
                data_q[wr_ptr_q] <= w_ext;
                tag_q[wr_ptr_q]  <= in_tag;
            end
        end
    end

endmodule : imm_ext_pipe
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_ext_pipe
// Purpose  : Scoreboard bench for imm_ext_pipe (IN_W=16, OUT_W=32, DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_ext_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic [1:0]  count;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    imm_ext_pipe #(
        .IN_W  (16),
        .OUT_W (32),
        .DEPTH (2),
        .TAG_W (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one input; record the expected result once acceptance is certain
    task automatic push(input logic [15:0] imm, input logic [1:0] mode,
                        input logic [4:0] tag, input logic [31:0] exp_data);
        int n;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("push_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back('{data: exp_data, tag: tag});
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    // Monitor: every accepted head beat is compared against the scoreboard
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", out_data, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_tag", 32'(out_tag), 32'(e.tag));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = 2'b00;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_tag",   32'(out_tag),   32'd0);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: one cycle from push to visible head
        push(16'h8001, 2'b00, 5'd3, 32'hFFFF_8001);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_data",  out_data,       32'hFFFF_8001);
        chk("lat_out_tag",   32'(out_tag),   32'd3);
        chk("lat_count",     32'(count),     32'd1);
        out_ready = 1'b1;
        drain();

        // Remaining modes through the scoreboard
        push(16'h8001, 2'b01, 5'd4, 32'h0000_8001);
        push(16'h1234, 2'b10, 5'd5, 32'h1234_0000);
        push(16'hFFFF, 2'b11, 5'd6, 32'hFFFF_FFFC);
        push(16'h7FFF, 2'b11, 5'd7, 32'h0001_FFFC);
        drain();

        // Fill under back-pressure, third push must be ignored
        out_ready = 1'b0;
        push(16'h0001, 2'b00, 5'd1, 32'h0000_0001);
        push(16'h0002, 2'b00, 5'd2, 32'h0000_0002);
        chk("full_count",    32'(count),    32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_imm   = 16'h0003;
        in_mode  = 2'b00;
        in_tag   = 5'd9;
        repeat (2) tick();
        in_valid = 1'b0;
        chk("full_hold_count", 32'(count),    32'd2);
        chk("full_hold_data",  out_data,      32'h0000_0001);
        out_ready = 1'b1;
        drain();
        chk("full_empty_valid", 32'(out_valid), 32'd0);

        // Streaming: one per cycle, occupancy stays at 1
        for (int i = 1; i <= 8; i++) begin
            push(16'(i), 2'b00, 5'(i + 10), 32'(i));
            chk("stream_count", 32'(count), 32'd1);
        end
        drain();

        // Flush while full with an input offered
        out_ready = 1'b0;
        push(16'h00A1, 2'b01, 5'd11, 32'h0000_00A1);
        push(16'h00A2, 2'b01, 5'd12, 32'h0000_00A2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_imm   = 16'h00AA;
        in_tag   = 5'd13;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush_count",     32'(count),     32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready",  32'(in_ready),  32'd1);

        // Flush wins over a push that would otherwise be accepted
        push(16'h00B1, 2'b01, 5'd14, 32'h0000_00B1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_imm   = 16'h00BB;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        tick();
        chk("flush_push_count", 32'(count),     32'd0);
        chk("flush_push_valid", 32'(out_valid), 32'd0);

        // Post-flush traffic still works
        out_ready = 1'b1;
        push(16'h0055, 2'b10, 5'd15, 32'h0055_0000);
        drain();

        // Asynchronous reset between edges
        out_ready = 1'b0;
        push(16'h8001, 2'b00, 5'd21, 32'hFFFF_8001);
        push(16'h1234, 2'b10, 5'd22, 32'h1234_0000);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data",  out_data,       32'd0);
        chk("arst_out_tag",   32'(out_tag),   32'd0);
        chk("arst_count",     32'(count),     32'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        chk("arst_in_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_imm_ext_pipe
`default_nettype wire
